// File: rtl/ifu_fetch_if.sv
// Fetch-stage signal bundle: imem request/response, decode handoff, redirect and status.
// master = the fetch unit, slave = memory/decode/execute side.
interface ifu_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              busy;
    logic              misalign_err;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc, busy, misalign_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc, busy, misalign_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// NPC instruction fetch stage: one outstanding imem read, held word handed to decode, redirects from execute.
// Optional IFU_ALIGN_CHECK_EN: misaligned redirects set misalign_err and park the unit in HALT until reset.
module ifu_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input logic         clk,
    input logic         reset_n,
    ifu_fetch_if.master bus
);

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              kill;
    logic              req_valid_q;
    logic              inst_valid_q;
    logic [INST_W-1:0] inst_out_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              busy_q;
    logic [ADDR_W-1:0] redir_pc;

`ifdef IFU_ALIGN_CHECK_EN
    logic misaligned;
    logic misalign_q;

    assign redir_pc          = bus.redirect_pc;
    assign misaligned        = |bus.redirect_pc[1:0];
    assign bus.misalign_err  = misalign_q;
`else
    logic unused_redirect_lsbs;

    // Without the checker the low bits are simply dropped, so every target is word aligned.
    assign redir_pc             = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
    assign bus.misalign_err     = 1'b0;
`endif

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst_out       = inst_out_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.busy           = busy_q;

    // NOTE: every register here uses <= so each branch reads the pre-edge pc/kill, never a value updated earlier in the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
            // NOTE: the held word and its PC are reset too, so decode never sees stale data after reset.
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
            busy_q       <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.redirect_valid) pc <= redir_pc;
                    state       <= S_REQ;
                    req_valid_q <= 1'b1;
                    busy_q      <= 1'b1;
                end

                S_REQ: begin
                    if (bus.redirect_valid) pc <= redir_pc;
                    if (bus.imem_req_ready) begin
                        // A request accepted alongside a redirect is already stale.
                        state       <= S_WAIT;
                        req_valid_q <= 1'b0;
                        kill        <= bus.redirect_valid;
                    end
                end

                S_WAIT: begin
                    if (bus.redirect_valid) pc <= redir_pc;
                    if (bus.imem_rsp_valid) begin
                        if (kill || bus.redirect_valid) begin
                            kill        <= 1'b0;
                            state       <= S_REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            inst_out_q   <= bus.imem_rsp_data;
                            inst_pc_q    <= pc;
                            inst_valid_q <= 1'b1;
                            state        <= S_HOLD;
                        end
                    end else if (bus.redirect_valid) begin
                        kill <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (bus.redirect_valid || bus.inst_ready) begin
                        // Redirect wins over the sequential step even when decode takes the word.
                        pc           <= bus.redirect_valid ? redir_pc : pc + ADDR_W'(4);
                        inst_valid_q <= 1'b0;
                        req_valid_q  <= 1'b1;
                        state        <= S_REQ;
                    end
                end

`ifdef IFU_ALIGN_CHECK_EN
                S_HALT: begin
                    state <= S_HALT;
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase

`ifdef IFU_ALIGN_CHECK_EN
            // Overrides whatever the state decode chose this edge; any in-flight response is ignored from HALT.
            if (bus.redirect_valid && misaligned && state != S_HALT) begin
                state        <= S_HALT;
                misalign_q   <= 1'b1;
                req_valid_q  <= 1'b0;
                inst_valid_q <= 1'b0;
                kill         <= 1'b0;
                busy_q       <= 1'b1;
            end
`endif
        end
    end

endmodule
